// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared funct3 codes, FSM states and access-size helpers for the
//            load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Undefined funct3 codes fall through to word width.
  function automatic size_t access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = SZ_B;
      F3_H, F3_HU: access_size = SZ_H;
      default:     access_size = SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (access_size(f3))
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Brief    : Selects the addressed byte/halfword of a bus read word and sign-
//            or zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = bus_rdata[{lane, 3'b000} +: 8];
  assign w_half = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    rdata_ext = bus_rdata;
    case (funct3)
      F3_B:    rdata_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   rdata_ext = {24'd0, w_byte};
      F3_H:    rdata_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   rdata_ext = {16'd0, w_half};
      default: rdata_ext = bus_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : RV32I load/store unit: byte-lane steering, handshaked bus access
//            with timeout abort, and pipeline stall request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        hold,
  output logic        stall_req,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned          c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]   c_timeout = c_cnt_w'(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [c_cnt_w-1:0] r_tcnt;
  logic [c_cnt_w-1:0] w_tcnt_inc;
  logic [1:0]         r_lane;
  logic [2:0]         r_funct3;
  logic               w_misaligned;
  logic               w_start;
  logic               w_ack;
  logic               w_timeout;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ext;

  assign w_misaligned = is_misaligned(funct3, addr[1:0]);
  assign w_tcnt_inc   = r_tcnt + c_cnt_one;

  // Store lane steering; loads read the whole word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (req_we) begin
      case (access_size(funct3))
        SZ_B: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        SZ_H: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .bus_rdata (bus_rdata),
    .lane      (r_lane),
    .funct3    (r_funct3),
    .rdata_ext (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    stall_req    = 1'b0;
    misalign     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_misaligned) begin
            misalign = 1'b1;
          end else begin
            stall_req    = 1'b1;
            w_start      = 1'b1;
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (bus_ack) begin
          w_ack        = 1'b1;
          w_state_next = DONE;
        end else if (w_tcnt_inc == c_timeout) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        // req_valid is deliberately ignored here so the parked instruction
        // is not issued a second time.
        if (!hold) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (!reset) begin
      stall_req = 1'b0;
      misalign  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      bus_err   <= 1'b0;
      r_tcnt    <= '0;
      r_lane    <= 2'd0;
      r_funct3  <= 3'd0;
    end else begin
      bus_err <= 1'b0;
      if (w_start) begin
        bus_req   <= 1'b1;
        bus_we    <= req_we;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= w_be;
        bus_wdata <= w_wdata;
        r_lane    <= addr[1:0];
        r_funct3  <= funct3;
        r_tcnt    <= '0;
      end
      if (r_state == BUSY) begin
        r_tcnt <= w_tcnt_inc;
      end
      if (w_ack) begin
        bus_req <= 1'b0;
        rdata   <= bus_we ? 32'd0 : w_ext;
      end
      if (w_timeout) begin
        bus_req <= 1'b0;
        bus_err <= 1'b1;
        rdata   <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the Memory stage of the RV32I pipeline and a handshaked data bus. It takes one request per instruction (address, store data, funct3, write enable), performs byte-lane steering and byte enables, waits for the bus acknowledge, and returns sign- or zero-extended load data for the Write Back register. While an access is outstanding it raises a stall request, which the hazard logic ORs into all pipeline stalls.

## Interface
- TIMEOUT_CYCLES, 255: number of BUSY cycles without `bus_ack` before the access is aborted.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  Memory stage holds a load or store.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU).
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data (rs2 value).
- hold  in  1  external stall of the Memory stage; keeps a completed result parked.
- stall_req  out  1  freeze pipeline; access not yet complete.
- rdata  out  32  extended load data, valid in DONE.
- misalign  out  1  current request is misaligned; no bus access issued.
- bus_err  out  1  one-cycle pulse on timeout abort.
- bus_req  out  1  bus request, held until acknowledged.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completes the access this cycle.
- bus_rdata  in  32  read word, valid when `bus_ack` is high.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if `req_valid` and the request is aligned, `stall_req`=1 combinationally. The bus outputs are registered from the request and the unit moves to BUSY.
- Alignment: H/HU/SH are misaligned when addr[0]=1; W/SW are misaligned when addr[1:0]≠0.
- Misaligned request: `misalign`=1 (level, combinational) while IDLE and `req_valid`. No stall and no bus traffic. The trap logic handles it.
- Undefined funct3 values (3, 6, 7) are treated as word accesses.
- BUSY: `bus_req`=1 and `stall_req`=1.
  - On `bus_ack`: capture the extended `bus_rdata` into `rdata` (loads only; stores leave `rdata` at 0), drop `bus_req`, and go to DONE.
- Timeout: a BUSY cycle counter counts up. If it reaches TIMEOUT_CYCLES without `bus_ack`, the unit drops `bus_req`, pulses `bus_err`, sets `rdata`=0 and goes to DONE. Counter width is clog2(TIMEOUT_CYCLES+1).
- DONE: `stall_req`=0 and `rdata` is stable. `req_valid` is ignored, so the same instruction is never re-issued.
  - `hold`=1 stays in DONE.
  - Otherwise the unit goes to IDLE on the next edge.
- Lanes: lane = addr[1:0].
  - SB: `bus_be` = 1<<lane, `bus_wdata` = {4{wdata[7:0]}}.
  - SH: `bus_be` = 0011 (lane 0) or 1100 (lane 2), `bus_wdata` = {2{wdata[15:0]}}.
  - SW: `bus_be` = 1111.
  - Loads drive `bus_be` = 1111.
  - LB/LBU take `bus_rdata` byte `lane`; LH/LHU take halfword lane[1]; B and H sign-extend, BU and HU zero-extend.

## Timing
- Reset (`reset`=0 at an edge) forces IDLE. Registered outputs clear: `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `rdata` and `bus_err` all go to 0.
- `stall_req` and `misalign` are gated to 0 while `reset`=0.
- A `bus_ack` arriving in the cycle after reset is ignored.
- Reset in BUSY abandons the access: `bus_req` is 0 after that edge.
- Minimum access: cycle N IDLE (stall), N+1 BUSY with `bus_ack`, N+2 DONE (no stall, `rdata` valid). That is 2 stall cycles; each wait cycle adds one.
- `bus_ack` outside BUSY is ignored.
- Back-to-back memory instructions: the DONE→IDLE edge is followed by IDLE evaluating the next request. There are no dead cycles beyond DONE.
- `bus_req` never deasserts in BUSY before `bus_ack` or timeout. Bus address, data, enables and write fields are stable throughout BUSY.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE, BUSY, DONE).
- Sub-module `load_extend` (combinational): inputs `bus_rdata`, lane, funct3; output is the extended 32-bit word.
- FSM, timeout counter and store steering live in `mem_access_unit`.

## Test plan
- LW at 0x100, ack on the first BUSY cycle, `bus_rdata`=0xDEADBEEF -> `stall_req` high for 2 cycles, `bus_addr`=0x100, `bus_be`=1111, `rdata`=0xDEADBEEF in DONE.
- LB at 0x103 with `bus_rdata`=0x80FF_0000 -> `rdata`=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SB at 0x201 with `wdata`=0x12345678 -> `bus_be`=0010, `bus_wdata`=0x78787878, `bus_we`=1. SH at 0x202 -> `bus_be`=1100, `bus_wdata`=0x56785678.
- LW at 0x102 -> `misalign`=1, `stall_req`=0, `bus_req` stays 0.
- TIMEOUT_CYCLES=4 with no ack -> `bus_req` high for 4 cycles, `bus_err` pulses once, `rdata`=0, DONE, then IDLE.
- `reset` low during BUSY, then `bus_ack` next cycle -> IDLE, all outputs 0, ack ignored. A `hold`=1 in DONE for 3 cycles keeps `rdata` stable and causes no re-issue.
